// File: rtl/scarv_cop_palu_subtractor_seq_if.sv
// Request/response handshake bundle between the COP issue stage and the
// digit-serial packed subtractor.
interface scarv_cop_palu_subtractor_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_pw;
  logic        req_bi;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_c;
  logic        rsp_bo;

  modport master (
    output req_valid, req_a, req_b, req_pw, req_bi, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_bo
  );

  modport slave (
    input  req_valid, req_a, req_b, req_pw, req_bi, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_bo
  );
endinterface

// File: rtl/scarv_cop_palu_subtractor_seq.sv
// Digit-serial packed subtractor: c = a - b - bi per lane, DW bits per cycle,
// LSB digit first, with borrows cut at lane boundaries.
module scarv_cop_palu_subtractor_seq #(
  parameter int unsigned DW = 4
) (
  input  logic                                g_clk,
  input  logic                                g_reset,
  input  logic                                flush,
  scarv_cop_palu_subtractor_seq_if.slave      bus
);

  localparam int unsigned NDIG = 32 / DW;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (!(DW == 1 || DW == 2 || DW == 4 || DW == 8 || DW == 16 || DW == 32)) begin : g_dw_check
    $error("scarv_cop_palu_subtractor_seq: DW must be one of 1,2,4,8,16,32");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [4:0]        lane_mask_q;
  logic              bi_q;
  logic              carry_q;
  logic [31:0]       c_q;
  logic              bo_q;
  logic              valid_q;

  logic [DW-1:0]     digit;
  logic              digit_cout;
  logic [31:0]       base;
  logic              last_digit;
  logic [4:0]        req_lane_mask;

  assign base       = 32'(cnt_q) * DW;
  assign last_digit = (32'(cnt_q) == NDIG - 1);

  // Lane mask = lanebits-1; a bit index is a lane start when its masked bits are zero.
  // Illegal pack widths fall back to a single 32-bit lane.
  always_comb begin
    req_lane_mask = 5'd31;
    case (bus.req_pw)
      3'b001:  req_lane_mask = 5'd31;
      3'b010:  req_lane_mask = 5'd15;
      3'b011:  req_lane_mask = 5'd7;
      3'b100:  req_lane_mask = 5'd3;
      3'b101:  req_lane_mask = 5'd1;
      default: req_lane_mask = 5'd31;
    endcase
  end

  // Ripple a + ~b + carry across the current digit, restarting the carry at lane starts.
  always_comb begin
    logic       carry;
    logic       cin;
    logic       abit;
    logic       nbbit;
    logic [4:0] idx;
    carry = carry_q;
    cin   = 1'b0;
    abit  = 1'b0;
    nbbit = 1'b0;
    idx   = '0;
    digit = '0;
    for (int unsigned j = 0; j < DW; j++) begin
      idx   = 5'(base) + 5'(j);
      abit  = a_q[idx];
      nbbit = ~b_q[idx];
      if (idx == 5'd0) begin
        cin = ~bi_q;
      end else if ((idx & lane_mask_q) == 5'd0) begin
        cin = 1'b1;
      end else begin
        cin = carry;
      end
      digit[j] = abit ^ nbbit ^ cin;
      carry    = (abit & nbbit) | (cin & (abit ^ nbbit));
    end
    digit_cout = carry;
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      lane_mask_q <= '0;
      bi_q        <= 1'b0;
      carry_q     <= 1'b0;
      c_q         <= '0;
      bo_q        <= 1'b0;
      valid_q     <= 1'b0;
    end else if (flush) begin
      // Flush wins over accept and over the response handshake.
      state_q <= StIdle;
      cnt_q   <= '0;
      c_q     <= '0;
      bo_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            a_q         <= bus.req_a;
            b_q         <= bus.req_b;
            lane_mask_q <= req_lane_mask;
            bi_q        <= bus.req_bi;
            carry_q     <= ~bus.req_bi;
            cnt_q       <= '0;
            c_q         <= '0;
            bo_q        <= 1'b0;
            state_q     <= StRun;
          end
        end
        StRun: begin
          c_q[base[4:0] +: DW] <= digit;
          carry_q              <= digit_cout;
          if (last_digit) begin
            bo_q    <= ~digit_cout;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_c     = c_q;
  assign bus.rsp_bo    = bo_q;

endmodule

// File: tb/tb_scarv_cop_palu_subtractor_seq.sv
// Directed self-checking bench for the digit-serial packed subtractor (DW=4).
module tb_scarv_cop_palu_subtractor_seq;

  localparam int unsigned NDIG = 8;

  logic g_clk;
  logic g_reset;
  logic flush;
  int   n_chk;
  int   n_fail;
  int   lat;

  scarv_cop_palu_subtractor_seq_if bus ();

  scarv_cop_palu_subtractor_seq #(.DW(4)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .flush   (flush),
    .bus     (bus)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge with
  // the operand inputs scrambled so latching is exercised.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] pw,
                       input logic bi);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_pw    = pw;
    bus.req_bi    = bi;
    bus.req_valid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    bus.req_valid = 1'b0;
    bus.req_a     = ~a;
    bus.req_b     = ~b;
    bus.req_pw    = 3'b001;
    bus.req_bi    = ~bi;
  endtask

  // Counts edges from the accept edge until rsp_valid, bounded.
  task automatic wait_rsp(output int edges);
    edges = 0;
    while (bus.rsp_valid !== 1'b1 && edges < 100) begin
      @(posedge g_clk);
      @(negedge g_clk);
      edges++;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] held_c;
    n_chk = 0;
    n_fail = 0;
    g_reset = 1'b1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_pw = 3'b001;
    bus.req_bi = 1'b0;
    bus.rsp_ready = 1'b0;

    @(posedge g_clk);
    @(negedge g_clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_c", bus.rsp_c, 32'h0);
    chk("reset_rsp_bo", 32'(bus.rsp_bo), 32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    g_reset = 1'b0;
    @(negedge g_clk);

    // 1: 1x32 underflow, latency check
    issue(32'h0000_0000, 32'h0000_0001, 3'b001, 1'b0);
    chk("t1_busy", 32'(bus.req_ready), 32'd0);
    wait_rsp(lat);
    chk("t1_latency", 32'(lat), 32'(NDIG));
    chk("t1_c", bus.rsp_c, 32'hFFFF_FFFF);
    chk("t1_bo", 32'(bus.rsp_bo), 32'd1);
    consume();
    chk("t1_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("t1_idle_valid", 32'(bus.rsp_valid), 32'd0);

    // 2: 4x8
    issue(32'h1020_3040, 32'h2010_3050, 3'b011, 1'b0);
    wait_rsp(lat);
    chk("t2_latency", 32'(lat), 32'(NDIG));
    chk("t2_c", bus.rsp_c, 32'hF010_00F0);
    chk("t2_bo", 32'(bus.rsp_bo), 32'd1);
    consume();

    // 3: 16x2, then borrow-in only affecting lane 0
    issue(32'h0000_0000, 32'h5555_5555, 3'b101, 1'b0);
    wait_rsp(lat);
    chk("t3a_c", bus.rsp_c, 32'hFFFF_FFFF);
    chk("t3a_bo", 32'(bus.rsp_bo), 32'd1);
    consume();
    issue(32'h0000_0000, 32'h0000_0000, 3'b101, 1'b1);
    wait_rsp(lat);
    chk("t3b_c", bus.rsp_c, 32'h0000_0003);
    chk("t3b_bo", 32'(bus.rsp_bo), 32'd0);
    consume();

    // 4: back-pressure on response with a pending request
    issue(32'h0000_0005, 32'h0000_0003, 3'b001, 1'b0);
    wait_rsp(lat);
    held_c = bus.rsp_c;
    chk("t4_first_c", held_c, 32'h0000_0002);
    bus.req_a = 32'h0000_0100;
    bus.req_b = 32'h0000_0001;
    bus.req_pw = 3'b100;
    bus.req_bi = 1'b0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge g_clk);
      @(negedge g_clk);
      chk("t4_hold_c", bus.rsp_c, held_c);
      chk("t4_hold_bo", 32'(bus.rsp_bo), 32'd0);
      chk("t4_hold_ready", 32'(bus.req_ready), 32'd0);
      chk("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
    end
    consume();
    chk("t4_after_hs_ready", 32'(bus.req_ready), 32'd1);
    chk("t4_after_hs_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge g_clk);
    @(negedge g_clk);
    bus.req_valid = 1'b0;
    chk("t4_second_accepted", 32'(bus.req_ready), 32'd0);
    wait_rsp(lat);
    chk("t4_second_latency", 32'(lat), 32'(NDIG));
    // 8x4: 0x00000100 - 0x00000001 -> nibble0 0-1=F, nibble2 1-0=1
    chk("t4_second_c", bus.rsp_c, 32'h0000_010F);
    chk("t4_second_bo", 32'(bus.rsp_bo), 32'd0);
    consume();

    // 5: reset in the middle of an op
    issue(32'h0000_0000, 32'h0000_0001, 3'b001, 1'b0);
    repeat (3) begin
      @(posedge g_clk);
      @(negedge g_clk);
    end
    chk("t5_partial_c", bus.rsp_c, 32'h0000_0FFF);
    g_reset = 1'b1;
    #1;
    chk("t5_reset_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_reset_c", bus.rsp_c, 32'h0);
    chk("t5_reset_ready", 32'(bus.req_ready), 32'd1);
    @(negedge g_clk);
    g_reset = 1'b0;
    @(negedge g_clk);
    issue(32'h0001_0000, 32'h0000_0001, 3'b010, 1'b0);
    wait_rsp(lat);
    chk("t5_latency", 32'(lat), 32'(NDIG));
    chk("t5_c", bus.rsp_c, 32'h0001_FFFF);
    chk("t5_bo", 32'(bus.rsp_bo), 32'd0);
    consume();

    // 6: illegal pw runs as 1x32
    issue(32'h0000_0005, 32'h0000_0003, 3'b111, 1'b0);
    wait_rsp(lat);
    chk("t6_c", bus.rsp_c, 32'h0000_0002);
    chk("t6_bo", 32'(bus.rsp_bo), 32'd0);
    consume();

    // 6b: flush mid-RUN discards the op
    issue(32'h1234_5678, 32'h0000_0001, 3'b001, 1'b0);
    @(posedge g_clk);
    @(negedge g_clk);
    flush = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    flush = 1'b0;
    chk("t6_flush_ready", 32'(bus.req_ready), 32'd1);
    chk("t6_flush_valid", 32'(bus.rsp_valid), 32'd0);
    wait_rsp(lat);
    chk("t6_flush_no_rsp", 32'(lat), 32'd100);

    // 6c: flush in IDLE blocks an accept
    bus.req_valid = 1'b1;
    flush = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    chk("t6_flush_blocks_accept", 32'(bus.req_ready), 32'd1);
    flush = 1'b0;
    bus.req_a = 32'h0000_0010;
    bus.req_b = 32'h0000_0001;
    bus.req_pw = 3'b001;
    bus.req_bi = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    bus.req_valid = 1'b0;
    chk("t6_accept_after_flush", 32'(bus.req_ready), 32'd0);
    wait_rsp(lat);
    chk("t6_after_flush_c", bus.rsp_c, 32'h0000_000E);
    chk("t6_after_flush_bo", 32'(bus.rsp_bo), 32'd0);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
